// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed seven-segment driver with a frame-synchronous shadow buffer.
// Latency: all outputs registered; a write is first displayed on digit 0 after the next frame boundary.
// Backpressure: none; wr_en is always accepted and later writes within a frame overwrite earlier ones.
module seg_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [4*NUM_DIGITS-1:0] wr_data,
  input  logic [NUM_DIGITS-1:0]   wr_blank,
  input  logic [NUM_DIGITS-1:0]   wr_dp,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done,
  output logic                    commit
);

  // The counter is shared by both states, so it is sized for the longer one.
  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  // One complete display image: nibbles, per-digit blank mask and decimal points.
  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] data;
    logic [NUM_DIGITS-1:0]   blank;
    logic [NUM_DIGITS-1:0]   dp;
  } disp_t;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  // Active-high segment pattern {g,f,e,d,c,b,a} for one hex digit.
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             frame_end;

  disp_t act_q, act_d;
  disp_t shd_q, shd_d;
  logic  pending_q, pending_d;

  logic [NUM_DIGITS-1:0] dig_sel_q, dig_sel_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  frame_done_q;
  logic                  commit_q, commit_d;

  // Scan state register: current phase, cycle count within the phase, digit index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic: BLANK guard then SHOW dwell per digit; the last digit's SHOW ends the frame.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    idx_d     = idx_q;
    frame_end = 1'b0;
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
        end
      end
      ST_SHOW: begin
        if (cnt_q == DWELL_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          if (idx_q == IDX_LAST) begin
            idx_d     = '0;
            frame_end = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Display buffers: writes land in the shadow; the active image only changes at a frame end.
  // A write coinciding with the frame end goes straight through so it is not held a whole frame.
  always_comb begin
    act_d     = act_q;
    shd_d     = shd_q;
    pending_d = pending_q;
    commit_d  = 1'b0;
    if (wr_en) begin
      shd_d.data  = wr_data;
      shd_d.blank = wr_blank;
      shd_d.dp    = wr_dp;
      pending_d   = 1'b1;
    end
    if (frame_end) begin
      if (wr_en) begin
        act_d.data  = wr_data;
        act_d.blank = wr_blank;
        act_d.dp    = wr_dp;
        pending_d   = 1'b0;
        commit_d    = 1'b1;
      end else if (pending_q) begin
        act_d     = shd_q;
        pending_d = 1'b0;
        commit_d  = 1'b1;
      end
    end
  end

  // Buffer registers; reset discards both images and any pending write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q     <= '0;
      shd_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      act_q     <= act_d;
      shd_q     <= shd_d;
      pending_q <= pending_d;
    end
  end

  // Output image for the upcoming cycle, derived from the next scan state so the pins are registered.
  always_comb begin
    dig_sel_d = '0;
    seg_d     = '0;
    dp_d      = 1'b0;
    if (state_d == ST_SHOW) begin
      dig_sel_d = NUM_DIGITS'(1) << idx_d;
      if (!act_d.blank[idx_d]) begin
        seg_d = hex_decode(act_d.data[{idx_d, 2'b00} +: 4]);
        dp_d  = act_d.dp[idx_d];
      end
    end
  end

  // Output registers; reset clears the pins immediately without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig_sel_q    <= '0;
      seg_q        <= '0;
      dp_q         <= 1'b0;
      frame_done_q <= 1'b0;
      commit_q     <= 1'b0;
    end else begin
      dig_sel_q    <= dig_sel_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_end;
      commit_q     <= commit_d;
    end
  end

  assign dig_sel    = dig_sel_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;
  assign commit     = commit_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

  localparam int ND    = 4;
  localparam int DW    = 4;
  localparam int BL    = 2;
  localparam int SLOT  = BL + DW;
  localparam int FRAME = ND * SLOT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic [3:0]  wr_blank = '0;
  logic [3:0]  wr_dp = '0;
  logic [3:0]  dig_sel;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;
  logic        commit;

  seg_scan_driver #(
    .NUM_DIGITS  (ND),
    .DWELL_CYCLES(DW),
    .BLANK_CYCLES(BL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .wr_blank  (wr_blank),
    .wr_dp     (wr_dp),
    .dig_sel   (dig_sel),
    .seg       (seg),
    .dp        (dp),
    .frame_done(frame_done),
    .commit    (commit)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]     data;
    logic [3:0]      blank;
    logic [3:0]      dpm;
    logic [3:0][6:0] exp_seg;
    logic [3:0]      exp_dp;
  } vec_t;

  vec_t       vecs [7];
  logic [6:0] hex_tbl [16];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: time since release decides the scan position; images are plain variables.
  int          t;
  logic [15:0] m_data, s_data;
  logic [3:0]  m_blank, m_dp, s_blank, s_dp;
  logic        m_pend, m_fd, m_cm;

  logic [6:0] cap_seg [4];
  logic       cap_dp [4];
  logic       cap_seen [4];
  int         commits;
  int         first_fd;

  task automatic model_reset();
    t = 0;
    m_data = '0; m_blank = '0; m_dp = '0;
    s_data = '0; s_blank = '0; s_dp = '0;
    m_pend = 1'b0; m_fd = 1'b0; m_cm = 1'b0;
  endtask

  task automatic model_edge(input logic we, input logic [15:0] d, input logic [3:0] b, input logic [3:0] p);
    t++;
    m_fd = ((t % FRAME) == 0);
    m_cm = 1'b0;
    if (we) begin
      s_data = d; s_blank = b; s_dp = p; m_pend = 1'b1;
    end
    if (m_fd && m_pend) begin
      m_data = s_data; m_blank = s_blank; m_dp = s_dp;
      m_pend = 1'b0; m_cm = 1'b1;
    end
  endtask

  task automatic expect_now(output logic [3:0] ed, output logic [6:0] es, output logic ep);
    int pos, d, w;
    pos = t % FRAME;
    d = pos / SLOT;
    w = pos % SLOT;
    ed = '0; es = '0; ep = 1'b0;
    if (w >= BL) begin
      ed = 4'(1 << d);
      if (!m_blank[d]) begin
        es = hex_tbl[m_data[4*d +: 4]];
        ep = m_dp[d];
      end
    end
  endtask

  // Compare the current cycle against the model, record per-digit captures, then advance one clock.
  task automatic step(input logic we, input logic [15:0] d, input logic [3:0] b, input logic [3:0] p);
    logic [3:0] ed;
    logic [6:0] es;
    logic       ep;
    expect_now(ed, es, ep);
    n_cmp++;
    if (dig_sel !== ed || seg !== es || dp !== ep || frame_done !== m_fd || commit !== m_cm) begin
      n_bad++;
      $display("FAIL scan t=%0d: got dig_sel=%b seg=%h dp=%b frame_done=%b commit=%b, want %b %h %b %b %b",
               t, dig_sel, seg, dp, frame_done, commit, ed, es, ep, m_fd, m_cm);
    end
    for (int k = 0; k < ND; k++) begin
      if (dig_sel === 4'(1 << k)) begin
        cap_seg[k] = seg; cap_dp[k] = dp; cap_seen[k] = 1'b1;
      end
    end
    if (commit === 1'b1) commits++;
    wr_en = we; wr_data = d; wr_blank = b; wr_dp = p;
    @(posedge clk);
    model_edge(we, d, b, p);
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 16'h0, 4'h0, 4'h0);
  endtask

  task automatic go_to_pos(input int p);
    for (int i = 0; i < FRAME && (t % FRAME) != p; i++) idle();
  endtask

  task automatic clear_caps();
    for (int k = 0; k < ND; k++) begin
      cap_seg[k] = 'x; cap_dp[k] = 1'bx; cap_seen[k] = 1'b0;
    end
  endtask

  task automatic capture_frame();
    clear_caps();
    for (int i = 0; i < FRAME; i++) idle();
  endtask

  task automatic check_caps(input string nm, input logic [3:0][6:0] es, input logic [3:0] ep);
    for (int k = 0; k < ND; k++) begin
      n_cmp++;
      if (!cap_seen[k] || cap_seg[k] !== es[k] || cap_dp[k] !== ep[k]) begin
        n_bad++;
        $display("FAIL %s digit%0d: got seen=%b seg=%h dp=%b, want seg=%h dp=%b",
                 nm, k, cap_seen[k], cap_seg[k], cap_dp[k], es[k], ep[k]);
      end
    end
  endtask

  task automatic check_int(input string nm, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    hex_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    // {data, blank, dp, expected seg {d3,d2,d1,d0}, expected dp}
    vecs[0] = '{16'h3A5F, 4'b0000, 4'b0010, {7'h4F, 7'h77, 7'h6D, 7'h71}, 4'b0010};
    vecs[1] = '{16'h8888, 4'b1000, 4'b0000, {7'h00, 7'h7F, 7'h7F, 7'h7F}, 4'b0000};
    vecs[2] = '{16'h0123, 4'b0000, 4'b1111, {7'h3F, 7'h06, 7'h5B, 7'h4F}, 4'b1111};
    vecs[3] = '{16'h4567, 4'b0000, 4'b0101, {7'h66, 7'h6D, 7'h7D, 7'h07}, 4'b0101};
    vecs[4] = '{16'h89AB, 4'b0000, 4'b0000, {7'h7F, 7'h6F, 7'h77, 7'h7C}, 4'b0000};
    vecs[5] = '{16'hCDEF, 4'b0101, 4'b1111, {7'h39, 7'h00, 7'h79, 7'h00}, 4'b1010};
    vecs[6] = '{16'h8888, 4'b1000, 4'b1000, {7'h00, 7'h7F, 7'h7F, 7'h7F}, 4'b0000};

    // Held in reset: everything low.
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({dig_sel, seg, dp, frame_done, commit} !== 14'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got dig_sel=%b seg=%h dp=%b fd=%b commit=%b, want all 0",
               dig_sel, seg, dp, frame_done, commit);
    end

    // First frame after release: scan order, first frame_done at cycle 24, all digits show 0.
    rst = 1'b0;
    model_reset();
    clear_caps();
    first_fd = -1;
    for (int i = 0; i < FRAME + 2; i++) begin
      if (frame_done === 1'b1 && first_fd < 0) first_fd = t;
      idle();
    end
    check_int("first_frame_done_cycle", first_fd, FRAME);
    check_caps("reset_frame", {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000);

    // Table vectors: write mid-frame, expect exactly one commit and the new image next frame.
    for (int v = 0; v < 7; v++) begin
      go_to_pos(3);
      step(1'b1, vecs[v].data, vecs[v].blank, vecs[v].dpm);
      commits = 0;
      go_to_pos(0);
      capture_frame();
      check_caps($sformatf("vec%0d", v), vecs[v].exp_seg, vecs[v].exp_dp);
      check_int($sformatf("vec%0d_commits", v), commits, 1);
    end

    // Two writes in one frame: the last one wins, one commit only.
    go_to_pos(3);
    step(1'b1, 16'h1111, 4'b0000, 4'b0000);
    repeat (5) idle();
    step(1'b1, 16'h2222, 4'b0000, 4'b0000);
    commits = 0;
    go_to_pos(0);
    capture_frame();
    check_caps("two_writes", {7'h5B, 7'h5B, 7'h5B, 7'h5B}, 4'b0000);
    capture_frame();
    check_int("two_writes_commits", commits, 1);

    // Write exactly on the boundary edge: committed at once, shown on the very next digit 0.
    go_to_pos(FRAME - 1);
    step(1'b1, 16'h0009, 4'b0000, 4'b0000);
    check_int("boundary_commit", int'(commit), 1);
    check_int("boundary_frame_done", int'(frame_done), 1);
    capture_frame();
    check_caps("boundary_write", {7'h3F, 7'h3F, 7'h3F, 7'h6F}, 4'b0000);

    // Randomized writes against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0)
        step(1'b1, 16'($urandom), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      else
        idle();
    end

    // Reset during digit 2 SHOW with a write pending: pins drop without a clock, data discarded.
    go_to_pos(1);
    step(1'b1, 16'h7777, 4'b0000, 4'b1111);
    go_to_pos(2 * SLOT + BL + 1);
    check_int("pre_reset_dig_sel", int'(dig_sel), 4);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({dig_sel, seg, dp, frame_done, commit} !== 14'h0) begin
      n_bad++;
      $display("FAIL async_reset: got dig_sel=%b seg=%h dp=%b fd=%b commit=%b, want all 0",
               dig_sel, seg, dp, frame_done, commit);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    commits = 0;
    capture_frame();
    check_caps("after_reset", {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000);
    capture_frame();
    check_caps("after_reset_next", {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000);
    check_int("after_reset_commits", commits, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Time-multiplexed seven-segment display driver for the elevator panel, showing floor number, direction and status.
- It is the output-side counterpart of the keypad matrix scanner: it drives digit-select lines and segment lines instead of strobing rows and reading columns.
- Display data arrives from the elevator controller through a write port. The write lands in a shadow buffer and is committed only at a frame boundary, so a digit never tears mid-frame.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8)
DWELL_CYCLES, 1000, clocks each digit is lit (>=1)
BLANK_CYCLES, 16, all-off guard clocks before each digit, for anti-ghosting (>=1)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
wr_en  input  1  single-cycle write strobe for display data
wr_data  input  4*NUM_DIGITS  hex nibbles; nibble i (bits 4i+3:4i) belongs to digit i
wr_blank  input  NUM_DIGITS  bit i=1 blanks digit i (segments and dp off), written with wr_en
wr_dp  input  NUM_DIGITS  decimal point per digit, written with wr_en
dig_sel  output  NUM_DIGITS  one-hot active-high digit enable
seg  output  7  active-high segments {g,f,e,d,c,b,a}
dp  output  1  active-high decimal point
frame_done  output  1  one-cycle pulse at end of each full scan
commit  output  1  one-cycle pulse when the shadow buffer is copied to the active buffer

Behaviour:
- Reset is asynchronous and active-high. While rst=1:
  - state=BLANK, digit index=0, cycle counter=0.
  - dig_sel=0, seg=0, dp=0, frame_done=0, commit=0.
  - Active and shadow buffers are all zero, including blank and dp bits; pending=0.
- All outputs are registered and change only on rising clk edges.
- The FSM has two states, BLANK and SHOW.
  - The counter runs 0..N-1 within each state and clears on every transition.
- BLANK:
  - dig_sel=0, seg=0, dp=0.
  - Lasts exactly BLANK_CYCLES clocks, then enters SHOW for the current index.
- SHOW:
  - dig_sel=1<<idx.
  - seg=hex_decode(active nibble idx) and dp=active dp[idx], unless active blank[idx]=1, in which case seg=0, dp=0 and dig_sel is still asserted.
  - Lasts exactly DWELL_CYCLES clocks, then enters BLANK with idx+1.
  - idx wraps from NUM_DIGITS-1 to 0.
- The first cycle after reset release is BLANK, then digit 0 is shown.
- Frame period = NUM_DIGITS*(BLANK_CYCLES+DWELL_CYCLES) clocks.
- Hex decode (hex value):
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
- Write port:
  - wr_en=1 loads wr_data, wr_blank and wr_dp into the shadow buffer and sets pending.
  - Back-to-back writes overwrite the shadow; the last write wins.
  - The write port has no backpressure.
- Frame boundary (the edge where SHOW of digit NUM_DIGITS-1 ends and BLANK with idx=0 begins):
  - frame_done=1 for that one cycle.
  - If pending=1: active<=shadow, pending<=0, commit=1 in the same cycle as frame_done.
  - The new values are therefore first visible on digit 0 of the next frame.
- Simultaneous wr_en on the boundary edge: the incoming wr_data/wr_blank/wr_dp go directly into active and shadow, commit=1, pending=0. The write is never lost and is never delayed by a frame.
- No pending write at the boundary: frame_done pulses and commit stays 0.
- At most one bit of dig_sel is ever high. dig_sel never changes directly from one digit to another without at least BLANK_CYCLES of all-zero.
- Reset asserted mid-frame: outputs go to zero immediately (asynchronously), and any pending shadow data is discarded.

Test Plan:
- Reset release, NUM_DIGITS=4, DWELL=4, BLANK=2:
  - dig_sel=0 for 2 cycles, then 0001 for 4 cycles, then 0 for 2, then 0010, and so on.
  - frame_done first pulses at cycle 24 after release.
  - seg=3F (all zeros displayed) on every digit.
- Write wr_data=16'h3A5F, dp=0010, blank=0000 mid-frame:
  - The current frame is unchanged.
  - commit and frame_done both pulse at the boundary.
  - Next frame shows digit0 seg=71, digit1 seg=6D with dp=1, digit2 seg=77, digit3 seg=4F.
- Two writes in one frame, 16'h1111 then 16'h2222:
  - Exactly one commit at the boundary.
  - All digits show seg=5B in the next frame.
- wr_en exactly on the boundary cycle with 16'h0009:
  - commit=1 on that cycle.
  - digit0 shows seg=6F in the immediately following SHOW.
- Blank mask 1000 with data 16'h8888:
  - digits 0-2 show seg=7F.
  - digit3 has dig_sel=1000 with seg=0 and dp=0.
- Assert rst during digit 2 SHOW with a write pending:
  - dig_sel, seg, dp and the pulses go to 0 without waiting for a clock edge.
  - After release, the display shows 3F (all zeros); the pending data is gone.
